pt_dec: RTL

//  PT2262-style OOK frame decoder: receive side of pt_enc. Samples the serial

---
 rtl/pt_pkg.sv | 47 ++++
 rtl/pt_dec_if.sv | 29 ++
 rtl/pt_pulse_meter.sv | 54 +++++
 rtl/pt_dec.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pt_pkg.sv
// Shared definitions for the PT2262-style OOK frame decoder.
// Holds the symbol codes, phase-length limits in multiples of alpha,
// the decoder state and phase-class enums and the phase classifier.
package pt_pkg;

   localparam int unsigned WORD_W  = 24;
   localparam int unsigned N_PULSE = 24;
   localparam int unsigned IDX_W   = 5;

   localparam logic [1:0] SYM_ZERO  = 2'b00;
   localparam logic [1:0] SYM_ONE   = 2'b11;
   localparam logic [1:0] SYM_FLOAT = 2'b01;

   localparam int unsigned SHORT_MIN = 2;
   localparam int unsigned SHORT_MAX = 7;
   localparam int unsigned LONG_MIN  = 9;
   localparam int unsigned LONG_MAX  = 15;
   localparam int unsigned SYNC_MIN  = 96;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_ARMED,
      ST_HIGH,
      ST_LOW
   } state_e;

   typedef enum logic [1:0] {
      PH_BAD,
      PH_SHORT,
      PH_LONG
   } phase_e;

   // Classify a closed phase of d ticks with a ticks per alpha.
   function automatic phase_e classify(input int unsigned d, input int unsigned a);
      if (d >= SHORT_MIN * a && d <= SHORT_MAX * a) return PH_SHORT;
      if (d >= LONG_MIN * a && d <= LONG_MAX * a) return PH_LONG;
      return PH_BAD;
   endfunction

   // A symbol is valid when its two pulse bits form one of the three codes.
   function automatic logic sym_ok(input logic [1:0] c);
      return (c == SYM_ZERO) || (c == SYM_ONE) || (c == SYM_FLOAT);
   endfunction

endpackage

// File: rtl/pt_dec_if.sv
// Line/handshake bundle of the OOK frame decoder.
//   i_in      raw OOK line into the decoder (asynchronous)
//   i_ready   downstream accepts o_out when o_valid && i_ready
//   o_out     decoded 24-bit word, first symbol in o_out[23:22]
//   o_valid   o_out holds an undelivered frame
//   o_error   one-cycle pulse on a malformed phase or symbol
//   o_overrun sticky: frame completed while o_valid pending
// master: the decoder side; slave: the line driver / consumer side.
interface pt_dec_if;
   import pt_pkg::*;

   logic  i_in;
   logic  i_ready;
   word_t o_out;
   logic  o_valid;
   logic  o_error;
   logic  o_overrun;

   modport master (
      input  i_in, i_ready,
      output o_out, o_valid, o_error, o_overrun
   );

   modport slave (
      output i_in, i_ready,
      input  o_out, o_valid, o_error, o_overrun
   );

endinterface

// File: rtl/pt_pulse_meter.sv
// Line front end: 2-flop synchroniser, edge detect and saturating phase timer.
//   clk, reset  system clock, synchronous active-high reset
//   i_line      raw asynchronous line
//   o_rise_c    synced line rose this cycle
//   o_fall_c    synced line fell this cycle
//   o_level     synced line level
//   o_dur       ticks spent in the current phase; on an edge cycle it holds
//               the length of the phase that just closed
module pt_pulse_meter #(
   parameter int unsigned CNT_W = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_line,
   output logic             o_rise_c,
   output logic             o_fall_c,
   output logic             o_level,
   output logic [CNT_W-1:0] o_dur
);

   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic [CNT_W-1:0] r_dur;
   logic             w_edge;

   assign w_edge = r_s2 ^ r_s3;

   // Timer restarts at 1 on the edge cycle so its value at the closing edge
   // is exactly the phase length; it holds at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_s3  <= 1'b0;
         r_dur <= '0;
      end else begin
         r_s1 <= i_line;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (w_edge) begin
            r_dur <= CNT_W'(1);
         end else if (r_dur != {CNT_W{1'b1}}) begin
            r_dur <= r_dur + CNT_W'(1);
         end
      end
   end

   assign o_rise_c = r_s2 & ~r_s3;
   assign o_fall_c = ~r_s2 & r_s3;
   assign o_level  = r_s2;
   assign o_dur    = r_dur;

endmodule

// File: rtl/pt_dec.sv
// PT2262-style OOK frame decoder: times line phases, rebuilds 12 tri-state
// symbols into a 24-bit word and offers it on a valid/ready handshake.
//   clk    system clock
//   reset  synchronous, active-high
//   bus    pt_dec_if.master: i_in, i_ready, o_out, o_valid, o_error, o_overrun
// Optional build macro PT_DEC_CONFIRM_EN: deliver a word only when two
// consecutive frames decode identically.
module pt_dec
   import pt_pkg::*;
#(
   parameter int unsigned TICKS_PER_ALPHA = 4,
   parameter int unsigned CNT_W           = 12
) (
   input  logic     clk,
   input  logic     reset,
   pt_dec_if.master bus
);

   localparam int unsigned PH_LIMIT   = LONG_MAX * TICKS_PER_ALPHA;
   localparam int unsigned SYNC_TICKS = SYNC_MIN * TICKS_PER_ALPHA;

   logic             w_rise;
   logic             w_fall;
   logic             w_level;
   logic [CNT_W-1:0] w_dur;
   logic [31:0]      w_dur32;
   phase_e           w_cls;
   logic             w_pulse_ok;
   logic             w_pbit;

   state_e           r_state;
   state_e           w_state_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   word_t            r_word;
   word_t            w_word_nxt;
   phase_e           r_hcls;
   phase_e           w_hcls_nxt;
   logic             w_err;
   logic             w_frame;
   logic             w_deliver;
   logic             w_take;

   word_t            r_out;
   logic             r_valid;
   logic             r_error;
   logic             r_overrun;

   pt_pulse_meter #(.CNT_W(CNT_W)) u_meter (
      .clk      (clk),
      .reset    (reset),
      .i_line   (bus.i_in),
      .o_rise_c (w_rise),
      .o_fall_c (w_fall),
      .o_level  (w_level),
      .o_dur    (w_dur)
   );

   assign w_dur32    = 32'(w_dur);
   assign w_cls      = classify(w_dur32, TICKS_PER_ALPHA);
   assign w_pulse_ok = (r_hcls == PH_SHORT && w_cls == PH_LONG) ||
                       (r_hcls == PH_LONG  && w_cls == PH_SHORT);
   assign w_pbit     = (r_hcls == PH_LONG);

   // State register and frame assembly registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_HUNT;
         r_idx   <= '0;
         r_word  <= '0;
         r_hcls  <= PH_BAD;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_word  <= w_word_nxt;
         r_hcls  <= w_hcls_nxt;
      end
   end

   // Next state: HUNT is silent; once armed, any malformed phase reports
   // an error and falls back to HUNT. Pulse bits shift straight into the
   // word because a symbol code equals its two pulse bits.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_word_nxt  = r_word;
      w_hcls_nxt  = r_hcls;
      w_err       = 1'b0;
      w_frame     = 1'b0;
      case (r_state)
         ST_HUNT: begin
            if (!w_level && w_dur32 >= SYNC_TICKS) w_state_nxt = ST_ARMED;
         end
         ST_ARMED: begin
            if (w_rise) begin
               w_state_nxt = ST_HIGH;
               w_idx_nxt   = '0;
            end
         end
         ST_HIGH: begin
            if (w_fall) begin
               // The high after the last data pulse opens the sync pulse.
               if (w_cls == PH_BAD ||
                   (r_idx == IDX_W'(N_PULSE) && w_cls != PH_SHORT)) begin
                  w_err       = 1'b1;
                  w_state_nxt = ST_HUNT;
               end else begin
                  w_hcls_nxt  = w_cls;
                  w_state_nxt = ST_LOW;
               end
            end else if (w_dur32 > PH_LIMIT) begin
               w_err       = 1'b1;
               w_state_nxt = ST_HUNT;
            end
         end
         ST_LOW: begin
            if (r_idx == IDX_W'(N_PULSE)) begin
               if (w_rise) begin
                  w_err       = 1'b1;
                  w_state_nxt = ST_HUNT;
               end else if (w_dur32 >= SYNC_TICKS) begin
                  w_frame     = 1'b1;
                  w_state_nxt = ST_ARMED;
               end
            end else if (w_rise) begin
               // Odd index closes a symbol: pair with the previous pulse bit.
               if (!w_pulse_ok || (r_idx[0] && !sym_ok({r_word[0], w_pbit}))) begin
                  w_err       = 1'b1;
                  w_state_nxt = ST_HUNT;
               end else begin
                  w_word_nxt  = {r_word[WORD_W-2:0], w_pbit};
                  w_idx_nxt   = r_idx + IDX_W'(1);
                  w_state_nxt = ST_HIGH;
               end
            end else if (w_dur32 > PH_LIMIT) begin
               w_err       = 1'b1;
               w_state_nxt = ST_HUNT;
            end
         end
         default: w_state_nxt = ST_HUNT;
      endcase
   end

`ifdef PT_DEC_CONFIRM_EN
   word_t r_ref;
   logic  r_ref_vld;

   assign w_deliver = w_frame & r_ref_vld & (r_ref == r_word);

   // Reference word of the previous good frame; an error forgets it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ref     <= '0;
         r_ref_vld <= 1'b0;
      end else if (w_err) begin
         r_ref_vld <= 1'b0;
      end else if (w_frame) begin
         r_ref     <= r_word;
         r_ref_vld <= 1'b1;
      end
   end
`else
   assign w_deliver = w_frame;
`endif

   assign w_take = r_valid & bus.i_ready;

   // Output stage: a frame landing on the accept cycle replaces the
   // outgoing word; otherwise a pending word blocks it and flags overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out     <= '0;
         r_valid   <= 1'b0;
         r_error   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_error <= w_err;
         if (w_deliver) begin
            if (!r_valid || w_take) begin
               r_out   <= r_word;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (w_take) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.o_out     = r_out;
   assign bus.o_valid   = r_valid;
   assign bus.o_error   = r_error;
   assign bus.o_overrun = r_overrun;

endmodule
